// File: rtl/smpl_test_pipe.sv
// Rasterizer sample-test stage: a 4-stage edge-function inside test with a global
// halt. Sideband data travels with each sample, and a saturating counter tracks emitted hits.
module smpl_test_pipe #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          halt_RnnnnL,
   input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_R14S,
   input  logic [COLORS*SIGFIG-1:0]      color_R14U,
   input  logic                          validSamp_R14H,
   input  logic [2*SIGFIG-1:0]           sample_R14S,
   output logic [AXIS*SIGFIG-1:0]        hit_R18S,
   output logic [COLORS*SIGFIG-1:0]      color_R18U,
   output logic                          hit_valid_R18H,
   output logic [31:0]                   hit_total_RnnnnU
);

   localparam int DW = 2*SIGFIG;

   // The edge arithmetic and the hit packing are written for triangles in 3-space.
   if (VERTS != 3 || AXIS != 3 || RADIX >= SIGFIG) begin : g_param_check
      $error("smpl_test_pipe: unsupported parameter combination");
   end

   typedef logic signed [SIGFIG-1:0] coord_t;
   typedef logic signed [DW-1:0]     prod_t;
   typedef logic signed [DW:0]       dist_t;

   typedef struct packed {
      logic                     valid;
      logic [SIGFIG-1:0]        sx;
      logic [SIGFIG-1:0]        sy;
      logic [SIGFIG-1:0]        z;
      logic [COLORS*SIGFIG-1:0] color;
   } side_t;

   coord_t tri_x [VERTS];
   coord_t tri_y [VERTS];
   coord_t samp_x, samp_y;
   side_t  side_r14, side_r15, side_r16, side_r17;

   coord_t dx_r15 [VERTS];
   coord_t dy_r15 [VERTS];
   prod_t  dxe [VERTS];
   prod_t  dye [VERTS];
   prod_t  pa_r16 [VERTS];
   prod_t  pb_r16 [VERTS];
   dist_t  dist_r17 [VERTS];

   logic        inside_r17;
   logic [31:0] hit_total_q;

   // Only v0.z is forwarded; the z of the other vertices does not affect the test.
   logic unused_tri_z;
   assign unused_tri_z = ^{tri_R14S[(1*AXIS+2)*SIGFIG +: SIGFIG],
                           tri_R14S[(2*AXIS+2)*SIGFIG +: SIGFIG]};

   for (genvar v = 0; v < VERTS; v++) begin : g_unpack
      assign tri_x[v] = tri_R14S[(v*AXIS+0)*SIGFIG +: SIGFIG];
      assign tri_y[v] = tri_R14S[(v*AXIS+1)*SIGFIG +: SIGFIG];
      assign dxe[v]   = {{SIGFIG{dx_r15[v][SIGFIG-1]}}, dx_r15[v]};
      assign dye[v]   = {{SIGFIG{dy_r15[v][SIGFIG-1]}}, dy_r15[v]};
   end

   assign samp_x = sample_R14S[0 +: SIGFIG];
   assign samp_y = sample_R14S[SIGFIG +: SIGFIG];

   always_comb begin
      // NOTE: combinational blocks assign every output a default first so no latch is inferred.
      side_r14       = '0;
      side_r14.valid = validSamp_R14H;
      side_r14.sx    = samp_x;
      side_r14.sy    = samp_y;
      side_r14.z     = tri_R14S[2*SIGFIG +: SIGFIG];
      side_r14.color = color_R14U;
   end

   // R14 -> R15: vertex offsets relative to the sample.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: the per-vertex arrays are pipeline state, not storage, so they are cleared on reset like any flop.
      if (!rst) begin
         for (int v = 0; v < VERTS; v++) begin
            dx_r15[v] <= '0;
            dy_r15[v] <= '0;
         end
         side_r15 <= '0;
      end else if (halt_RnnnnL) begin
         // NOTE: sequential state always uses non-blocking assignment so the stages update together.
         for (int v = 0; v < VERTS; v++) begin
            dx_r15[v] <= tri_x[v] - samp_x;
            dy_r15[v] <= tri_y[v] - samp_y;
         end
         side_r15 <= side_r14;
      end
   end

   // R15 -> R16: the two cross-product terms of each edge function.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < VERTS; i++) begin
            pa_r16[i] <= '0;
            pb_r16[i] <= '0;
         end
         side_r16 <= '0;
      end else if (halt_RnnnnL) begin
         for (int i = 0; i < VERTS; i++) begin
            pa_r16[i] <= dxe[i] * dye[(i+1) % VERTS];
            pb_r16[i] <= dxe[(i+1) % VERTS] * dye[i];
         end
         side_r16 <= side_r15;
      end
   end

   // R16 -> R17: edge distances with one guard bit so the difference never wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < VERTS; i++) dist_r17[i] <= '0;
         side_r17 <= '0;
      end else if (halt_RnnnnL) begin
         for (int i = 0; i < VERTS; i++)
            dist_r17[i] <= {pa_r16[i][DW-1], pa_r16[i]} - {pb_r16[i][DW-1], pb_r16[i]};
         side_r17 <= side_r16;
      end
   end

   // Tie rule: edges 0 and 2 own their boundary, edge 1 does not, so shared edges hit once.
   always_comb begin
      inside_r17 = 1'b0;
      inside_r17 = (dist_r17[0][DW] | (dist_r17[0] == '0)) &
                   dist_r17[1][DW] &
                   (dist_r17[2][DW] | (dist_r17[2] == '0));
   end

   // R17 -> R18: output registers and the debug hit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_R18S       <= '0;
         color_R18U     <= '0;
         hit_valid_R18H <= 1'b0;
         hit_total_q    <= '0;
      end else if (halt_RnnnnL) begin
         hit_R18S       <= {side_r17.z, side_r17.sy, side_r17.sx};
         color_R18U     <= side_r17.color;
         hit_valid_R18H <= side_r17.valid & inside_r17;
         if (hit_valid_R18H && (hit_total_q != '1))
            hit_total_q <= hit_total_q + 32'd1;
      end
   end

   assign hit_total_RnnnnU = hit_total_q;

endmodule
